prog_ctr: RTL and testbench



---
 rtl/cpu_pkg.sv | 12 +
 rtl/prog_ctr.sv | 54 +++++
 tb/tb_prog_ctr.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: program counter width, address type and PC sequencer states.
// Combinational types only; no latency or backpressure.
package cpu_pkg;
    localparam int PC_W = 10;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {
        IDLE,
        RUN
    } pc_state_e;
endpackage

// File: rtl/prog_ctr.sv
// Program counter: holds the current instruction address, steps +1 or takes ALU-gated abs/rel branches.
// One-cycle registered output; Start high stalls the PC and suppresses branches (no other flow control).
module prog_ctr
    import cpu_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    input  logic BranchAbsEn,
    input  logic BranchRelEn,
    input  logic ALU_flag,
    input  pc_t  Target,
    output pc_t  ProgCtr
);

    pc_state_e state_q, state_d;
    pc_t       pc_q, pc_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (Start) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            // Two's complement wrap makes an unsigned add equal a signed offset add.
            if (BranchAbsEn && ALU_flag) begin
                pc_d = Target;
            end else if (BranchRelEn && ALU_flag) begin
                pc_d = pc_q + Target;
            end else begin
                pc_d = pc_q + pc_t'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ProgCtr = pc_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr: vector table for sequencing/branches plus reset and stall sequences.
module tb_prog_ctr;
    import cpu_pkg::*;

    logic Clk = 1'b0;
    logic Reset, Start, BranchAbsEn, BranchRelEn, ALU_flag;
    pc_t  Target;
    pc_t  ProgCtr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic start;
        logic abs_en;
        logic rel_en;
        logic flag;
        pc_t  target;
        pc_t  exp_pc;
    } vec_t;

    vec_t vecs[$];

    prog_ctr dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .BranchAbsEn(BranchAbsEn),
        .BranchRelEn(BranchRelEn),
        .ALU_flag   (ALU_flag),
        .Target     (Target),
        .ProgCtr    (ProgCtr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input pc_t act, input pc_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic r, input logic f, input pc_t t);
        Start       = s;
        BranchAbsEn = a;
        BranchRelEn = r;
        ALU_flag    = f;
        Target      = t;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic add(input logic s, input logic a, input logic r, input logic f,
                       input int t, input int e);
        vec_t v;
        v.start  = s;
        v.abs_en = a;
        v.rel_en = r;
        v.flag   = f;
        v.target = pc_t'(t);
        v.exp_pc = pc_t'(e);
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Start held: stays at 0 and enters RUN
        add(1, 0, 0, 0, 0,     0);
        add(1, 0, 0, 0, 0,     0);
        add(1, 0, 0, 0, 0,     0);
        // sequencing after release
        add(0, 0, 0, 0, 0,     1);
        add(0, 0, 0, 0, 0,     2);
        add(0, 0, 0, 0, 0,     3);
        // absolute branch: flag low not taken, then taken
        add(0, 1, 0, 0, 100,   4);
        add(0, 1, 0, 1, 3,     3);
        add(0, 1, 0, 1, 100,   100);
        // relative branches
        add(0, 0, 1, 1, 'h3FC, 96);
        add(0, 0, 1, 1, 20,    116);
        add(0, 0, 1, 0, 20,    117);
        // both enables: absolute wins
        add(0, 1, 1, 1, 7,     7);
        // zero offset self-loop, then -1
        add(0, 0, 1, 1, 0,     7);
        add(0, 0, 1, 1, 'h3FF, 6);
        add(0, 0, 1, 1, 'h3FF, 5);
        // 5 + (-6) wraps to 1023, then 1023+1 wraps to 0
        add(0, 0, 1, 1, 'h3FA, 1023);
        add(0, 0, 0, 0, 0,     0);
        // absolute to 1023, then sequential wrap
        add(0, 1, 0, 1, 'h3FF, 1023);
        add(0, 0, 0, 0, 0,     0);
        // Start high mid-run suppresses a branch request
        add(1, 1, 0, 1, 50,    0);
        add(1, 0, 1, 1, 9,     0);
        add(0, 0, 0, 0, 0,     1);
        add(0, 0, 0, 0, 0,     2);

        // reset asserted before any edge
        drive(0, 0, 0, 0, 0);
        Reset = 1'b1;
        #1;
        check("reset_initial", ProgCtr, 0);
        step();
        check("reset_after_edge", ProgCtr, 0);
        Reset = 1'b0;

        // IDLE hold without Start
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("idle_hold_%0d", i), ProgCtr, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].abs_en, vecs[i].rel_en, vecs[i].flag, vecs[i].target);
            step();
            check($sformatf("vec_%0d", i), ProgCtr, vecs[i].exp_pc);
        end

        // one more sequential edge to reach 3, then async reset between edges
        drive(0, 0, 0, 0, 0);
        step();
        check("pre_reset_run", ProgCtr, 3);
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_midcycle", ProgCtr, 0);
        step();
        check("reset_held_edge", ProgCtr, 0);
        Reset = 1'b0;

        // back in IDLE: no sequencing without Start
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_reset_idle_%0d", i), ProgCtr, 0);
        end

        // restart
        drive(1, 0, 0, 0, 0);
        step();
        check("restart_hold", ProgCtr, 0);
        drive(0, 0, 0, 0, 0);
        step();
        check("restart_run", ProgCtr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
